// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart transmitter arbiter: FSM state encoding,
// counter/index width helpers and a reference round-robin pick function.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DR,
    SEND
  } arb_state_t;

  localparam int unsigned MAX_REQ = 8;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot round-robin pick over the low n bits of req, scanning upward from ptr.
  function automatic logic [MAX_REQ-1:0] rr_next(input logic [2:0] ptr,
                                                 input logic [MAX_REQ-1:0] req,
                                                 input int unsigned n);
    logic [MAX_REQ-1:0] gnt;
    logic [2:0]         idx;
    gnt = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 3'((32'(ptr) + k) % n);
      if (k < n && gnt == '0 && req[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest request at or above ptr, otherwise
// lowest request overall (masked / unmasked two-pass priority encode).
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] lo_masked;
  logic [N-1:0] lo_any;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (i >= 32'(ptr));
    end
    masked    = req & mask;
    lo_masked = masked & (~masked + ONE);
    lo_any    = req & (~req + ONE);
    gnt       = (|masked) ? lo_masked : lo_any;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart transmitter between NR_REQ requesters,
// with burst locking, forced rotation after MAX_BURST words and a gap timeout.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NR_REQ      = 4,
  parameter int unsigned NR_BITS     = 8,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_REQ*NR_BITS-1:0] req_d,
  input  logic [NR_REQ-1:0]         req_dv,
  input  logic [NR_REQ-1:0]         req_last,
  output logic [NR_REQ-1:0]         req_dr,
  output logic [NR_REQ-1:0]         grant,
  output logic                      busy,
  output logic [NR_BITS-1:0]        uart_tx_d,
  output logic                      uart_tx_dv,
  input  logic                      uart_tx_dr
);

  localparam int unsigned PW = idx_width(NR_REQ);
  localparam int unsigned BW = cnt_width(MAX_BURST);
  localparam int unsigned GW = cnt_width(GAP_TIMEOUT);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_TIMEOUT);

  arb_state_t         state, state_nxt;
  logic [NR_REQ-1:0]  grant_nxt;
  logic [PW-1:0]      ptr, ptr_nxt;
  logic [BW-1:0]      burst_cnt, burst_nxt;
  logic [GW-1:0]      gap_cnt, gap_nxt;
  logic               last_q, last_nxt;
  logic [NR_BITS-1:0] d_nxt;
  logic               dv_nxt;

  logic [NR_REQ-1:0]  pick;
  logic [PW-1:0]      gidx;
  logic               xfer;
  logic               last_g;
  logic               release_g;
  logic [NR_BITS-1:0] words [NR_REQ];

  for (genvar i = 0; i < NR_REQ; i++) begin : g_split
    assign words[i] = req_d[i*NR_BITS +: NR_BITS];
  end

  rr_pick #(.N(NR_REQ), .PW(PW)) u_pick (
    .req (req_dv),
    .ptr (ptr),
    .gnt (pick)
  );

  assign req_dr = (state == LOAD) ? grant : '0;
  assign busy   = (state != IDLE);
  assign xfer   = |(req_dv & req_dr);
  assign last_g = |(req_last & grant);

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    burst_nxt = burst_cnt;
    gap_nxt   = gap_cnt;
    last_nxt  = last_q;
    d_nxt     = uart_tx_d;
    dv_nxt    = uart_tx_dv;
    release_g = 1'b0;
    case (state)
      IDLE: begin
        if (|req_dv) begin
          grant_nxt = pick;
          burst_nxt = '0;
          gap_nxt   = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          d_nxt     = words[gidx];
          last_nxt  = last_g;
          burst_nxt = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BW'(1);
          state_nxt = WAIT_DR;
        end else begin
          gap_nxt = (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + GW'(1);
          // burst_cnt==0 means the requester withdrew before its first word
          if (burst_cnt == '0 || gap_nxt == GAP_MAX) release_g = 1'b1;
        end
      end
      WAIT_DR: begin
        if (uart_tx_dr) begin
          dv_nxt    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (!uart_tx_dr) begin
          dv_nxt = 1'b0;
          if (last_q || burst_cnt == BURST_MAX) begin
            release_g = 1'b1;
          end else begin
            gap_nxt   = '0;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Single release point: last and MAX_BURST together still rotate only once.
    if (release_g) begin
      grant_nxt = '0;
      state_nxt = IDLE;
      ptr_nxt   = (gidx == PW'(NR_REQ - 1)) ? '0 : gidx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      ptr        <= '0;
      burst_cnt  <= '0;
      gap_cnt    <= '0;
      last_q     <= 1'b0;
      uart_tx_d  <= '0;
      uart_tx_dv <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      ptr        <= ptr_nxt;
      burst_cnt  <= burst_nxt;
      gap_cnt    <= gap_nxt;
      last_q     <= last_nxt;
      uart_tx_d  <= d_nxt;
      uart_tx_dv <= dv_nxt;
    end
  end

endmodule
